score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_pkg.sv | 18 +
 rtl/holdoff_timer.sv | 31 +++
 rtl/score_keeper.sv | 118 +++++++++++
 tb/tb_score_keeper.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the two-player score keeper.
// Used by score_keeper and its testbench.
package score_pkg;

    localparam int SCORE_W = 4;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        HOLDOFF = 2'd2,
        OVER    = 2'd3
    } state_t;

endpackage

// File: rtl/holdoff_timer.sv
// Down-counter that masks point pulses for CYCLES cycles after a point.
// done is high in the last masked cycle so the FSM leaves on that edge.
module holdoff_timer #(
    parameter int CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    output logic done
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= W'(CYCLES);
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == W'(1));

endmodule

// File: rtl/score_keeper.sv
// Two-player game score keeper with per-point holdoff and win detection.
// Define SCORE_WIN_BY_TWO_EN to require a two-point lead, with deuce folding.
module score_keeper
    import score_pkg::*;
#(
    parameter int WIN_SCORE      = 5,
    parameter int HOLDOFF_CYCLES = 50000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               p1_point,
    input  logic               p2_point,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [1:0]         winner,
    output logic               game_active
);

    localparam logic [SCORE_W:0]   WIN   = (SCORE_W + 1)'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] DEUCE = SCORE_W'(WIN_SCORE - 1);

    state_t             state, state_n;
    logic [SCORE_W-1:0] s1_n, s2_n;
    logic [1:0]         win_n;
    logic               active_n;
    logic               load, clear, done;
    logic               lone;

    // Scorer's new score, one bit wider so the win compare never wraps
    logic [SCORE_W:0]   mine;
    logic [SCORE_W-1:0] other;
    logic [SCORE_W-1:0] mine_n, other_n;
    logic               won, tie;

    holdoff_timer #(
        .CYCLES(HOLDOFF_CYCLES)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .clear(clear),
        .done (done)
    );

    assign lone = p1_point ^ p2_point;

    always_comb begin
        mine  = p1_point ? {1'b0, score_p1} + 1'b1
                         : {1'b0, score_p2} + 1'b1;
        other = p1_point ? score_p2 : score_p1;
`ifdef SCORE_WIN_BY_TWO_EN
        won = (mine >= WIN) && (mine >= {1'b0, other} + 2'd2);
        tie = (mine == {1'b0, other}) && (mine >= WIN - 1'b1);
`else
        won = (mine == WIN);
        tie = 1'b0;
`endif
        mine_n  = tie ? DEUCE : mine[SCORE_W-1:0];
        other_n = tie ? DEUCE : other;
    end

    always_comb begin
        state_n = state;
        s1_n    = score_p1;
        s2_n    = score_p2;
        win_n   = winner;
        load    = 1'b0;
        clear   = 1'b0;
        if (start) begin
            state_n = PLAY;
            s1_n    = '0;
            s2_n    = '0;
            win_n   = WIN_NONE;
            clear   = 1'b1;
        end else begin
            unique case (state)
                IDLE: ;
                PLAY: begin
                    if (lone) begin
                        s1_n = p1_point ? mine_n : other_n;
                        s2_n = p1_point ? other_n : mine_n;
                        if (won) begin
                            state_n = OVER;
                            win_n   = p1_point ? WIN_P1 : WIN_P2;
                        end else begin
                            state_n = HOLDOFF;
                            load    = 1'b1;
                        end
                    end
                end
                HOLDOFF: begin
                    if (done) state_n = PLAY;
                end
                OVER: ;
                default: state_n = IDLE;
            endcase
        end
        active_n = (state_n == PLAY) || (state_n == HOLDOFF);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            score_p1    <= '0;
            score_p2    <= '0;
            winner      <= WIN_NONE;
            game_active <= 1'b0;
        end else begin
            state       <= state_n;
            score_p1    <= s1_n;
            score_p2    <= s2_n;
            winner      <= win_n;
            game_active <= active_n;
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Randomized and directed bench for score_keeper against a rule-level model.
// Build with SCORE_WIN_BY_TWO_EN to also exercise the deuce scenario.
module tb_score_keeper;

    localparam int WIN  = 3;
    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       p1_point;
    logic       p2_point;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [1:0] winner;
    logic       game_active;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integers following the game rules
    int m1, m2, mw, mhold;
    bit mplay, mover;

    always #5 clk = ~clk;

    score_keeper #(
        .WIN_SCORE     (WIN),
        .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .p1_point   (p1_point),
        .p2_point   (p2_point),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .winner     (winner),
        .game_active(game_active)
    );

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m1 = 0; m2 = 0; mw = 0; mhold = 0;
        mplay = 0; mover = 0;
    endtask

    task automatic model_score(input bit by_p1);
        int me, oth;
        bit win, tie;
        me  = by_p1 ? m1 + 1 : m2 + 1;
        oth = by_p1 ? m2 : m1;
`ifdef SCORE_WIN_BY_TWO_EN
        win = (me >= WIN) && (me - oth >= 2);
        tie = (me == oth) && (me >= WIN - 1);
`else
        win = (me == WIN);
        tie = 0;
`endif
        if (tie) begin
            me  = WIN - 1;
            oth = WIN - 1;
        end
        if (by_p1) begin m1 = me; m2 = oth; end
        else       begin m2 = me; m1 = oth; end
        if (win) begin
            mover = 1;
            mw    = by_p1 ? 1 : 2;
        end else begin
            mhold = HOLD;
        end
    endtask

    task automatic model_step(input bit st, input bit a, input bit b);
        if (st) begin
            m1 = 0; m2 = 0; mw = 0; mhold = 0;
            mplay = 1; mover = 0;
        end else if (mplay && !mover) begin
            if (mhold > 0) mhold--;
            else if (a ^ b) model_score(a);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_s1"}, 16'(score_p1), 16'(m1));
        check({tag, "_s2"}, 16'(score_p2), 16'(m2));
        check({tag, "_win"}, 16'(winner), 16'(mw));
        check({tag, "_act"}, 16'(game_active), 16'(mplay && !mover));
    endtask

    task automatic step(input bit st, input bit a, input bit b,
                        input string tag);
        start    = st;
        p1_point = a;
        p2_point = b;
        @(posedge clk);
        model_step(st, a, b);
        #1;
        start    = 0;
        p1_point = 0;
        p2_point = 0;
        compare_all(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, "idle");
    endtask

    task automatic do_reset();
        reset = 1;
        start = 0; p1_point = 0; p2_point = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("rst");
        reset = 0;
    endtask

    initial begin
        do_reset();

        // First point lands the cycle after the pulse
        step(1, 0, 0, "start");
        step(0, 1, 0, "p1");
        check("first_s1", 16'(score_p1), 16'd1);
        check("first_act", 16'(game_active), 16'd1);
        check("first_win", 16'(winner), 16'd0);

        // Holdoff masks a pulse 2 cycles later, not 5 cycles later
        step(0, 0, 0, "h1");
        step(0, 0, 1, "h2");
        check("hold_ign", 16'(score_p2), 16'd0);
        idle(2);
        step(0, 0, 1, "h5");
        check("hold_cnt", 16'(score_p2), 16'd1);
        idle(HOLD);

        // P1 wins 3:0, then everything is frozen until start
        step(1, 0, 0, "start");
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, "win_pt");
            if (k < 2) idle(HOLD);
        end
        check("win_s1", 16'(score_p1), 16'd3);
        check("win_code", 16'(winner), 16'd1);
        step(0, 1, 0, "over_p1");
        step(0, 0, 1, "over_p2");
        check("over_s1", 16'(score_p1), 16'd3);
        check("over_s2", 16'(score_p2), 16'd0);
        step(1, 0, 0, "restart");
        check("restart_s1", 16'(score_p1), 16'd0);
        check("restart_win", 16'(winner), 16'd0);

        // Simultaneous points are ignored and play continues
        step(0, 1, 1, "both");
        check("both_s1", 16'(score_p1), 16'd0);
        check("both_s2", 16'(score_p2), 16'd0);
        step(0, 1, 0, "after_both");
        check("after_both_s1", 16'(score_p1), 16'd1);
        idle(HOLD);

        // Asynchronous reset in holdoff at 2:1
        step(1, 0, 0, "start");
        step(0, 1, 0, "a"); idle(HOLD);
        step(0, 1, 0, "b"); idle(HOLD);
        step(0, 0, 1, "c"); idle(1);
        check("pre_rst_s1", 16'(score_p1), 16'd2);
        reset = 1;
        model_reset();
        #1;
        compare_all("async_rst");
        check("async_act", 16'(game_active), 16'd0);
        @(posedge clk);
        #1;
        reset = 0;
        step(0, 1, 0, "idle_pt");
        check("idle_ign", 16'(score_p1), 16'd0);

`ifdef SCORE_WIN_BY_TWO_EN
        step(1, 0, 0, "start");
        step(0, 1, 0, "d"); idle(HOLD);
        step(0, 1, 0, "d"); idle(HOLD);
        step(0, 0, 1, "d"); idle(HOLD);
        step(0, 0, 1, "d"); idle(HOLD);
        step(0, 1, 0, "adv");
        check("adv_s1", 16'(score_p1), 16'd3);
        check("adv_win", 16'(winner), 16'd0);
        idle(HOLD);
        step(0, 0, 1, "deuce");
        check("deuce_s1", 16'(score_p1), 16'd2);
        check("deuce_s2", 16'(score_p2), 16'd2);
        idle(HOLD);
        step(0, 1, 0, "adv2"); idle(HOLD);
        step(0, 1, 0, "win2");
        check("w2_s1", 16'(score_p1), 16'd4);
        check("w2_code", 16'(winner), 16'd1);
`endif

        // Random play against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit st, a, b;
            r  = $urandom_range(0, 9);
            st = ($urandom_range(0, 63) == 0) || (i == 0);
            a  = (r < 2) || (r == 4);
            b  = (r == 2) || (r == 3) || (r == 4);
            step(st, a, b, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
